// File: rtl/alarm_chime.sv
// Hourly chime and daily alarm driven from the BCD time-of-day counter.
// The alarm has a stop/snooze state machine. Every output is registered from the next-state decode.
module alarm_chime #(
  parameter int unsigned ALARM_SECS = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  input  logic       CHIME_EN,
  input  logic       AL_EN,
  input  logic       AL_LD,
  input  logic [7:0] AL_H,
  input  logic [7:0] AL_M,
  input  logic       STOP,
  input  logic       SNZ,
  output logic [7:0] AH_Q,
  output logic [7:0] AM_Q,
  output logic       BEEP,
  output logic       TONE,
  output logic       RINGING,
  output logic       SNOOZING
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [9:0] RING_LAST = 10'(ALARM_SECS - 1);
  localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_MIN * 60 - 1);

  state_t     state, state_n;
  logic [9:0] sec_cnt, cnt_n;
  logic [7:0] prev_s;
  logic       sb, match, load_ok, chime_lo, chime_hi;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  assign sb      = (Q_S != prev_s);
  assign match   = sb && AL_EN && (Q_H == AH_Q) && (Q_M == AM_Q) && (Q_S == 8'h00);
  assign load_ok = bcd_ok(AL_H) && bcd_ok(AL_M) && (AL_H <= 8'h23) && (AL_M <= 8'h59);

  // Even seconds 50..58: tens digit 5, units digit even and at most 8.
  assign chime_lo = CHIME_EN && (Q_M == 8'h59) && (Q_S[7:4] == 4'h5)
                    && !Q_S[0] && (Q_S[3:0] <= 4'h8);
  assign chime_hi = CHIME_EN && (Q_M == 8'h00) && (Q_S == 8'h00);

  always_comb begin
    state_n = state;
    cnt_n   = sec_cnt;
    if (!AL_EN) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (match) begin
            state_n = RING;
            cnt_n   = '0;
          end
        end
        RING: begin
          if (STOP) begin
            state_n = IDLE;
          end else if (SNZ) begin
            state_n = SNOOZE;
            cnt_n   = '0;
          end else if (sb) begin
            if (sec_cnt == RING_LAST) state_n = IDLE;
            else                      cnt_n   = sec_cnt + 10'd1;
          end
        end
        SNOOZE: begin
          if (STOP) begin
            state_n = IDLE;
          end else if (sb) begin
            if (sec_cnt == SNZ_LAST) begin
              state_n = RING;
              cnt_n   = '0;
            end else begin
              cnt_n = sec_cnt + 10'd1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      state    <= IDLE;
      sec_cnt  <= '0;
      prev_s   <= '0;
      AH_Q     <= '0;
      AM_Q     <= '0;
      BEEP     <= 1'b0;
      TONE     <= 1'b0;
      RINGING  <= 1'b0;
      SNOOZING <= 1'b0;
    end else begin
      state    <= state_n;
      sec_cnt  <= cnt_n;
      prev_s   <= Q_S;
      if (AL_LD && load_ok) begin
        AH_Q <= AL_H;
        AM_Q <= AL_M;
      end
      RINGING  <= (state_n == RING);
      SNOOZING <= (state_n == SNOOZE);
      // The alarm takes precedence over both chime pitches.
      if (state_n == RING) begin
        BEEP <= 1'b1;
        TONE <= 1'b1;
      end else if (chime_hi) begin
        BEEP <= 1'b1;
        TONE <= 1'b1;
      end else if (chime_lo) begin
        BEEP <= 1'b1;
        TONE <= 1'b0;
      end else begin
        BEEP <= 1'b0;
        TONE <= 1'b0;
      end
    end
  end

endmodule
